// File: rtl/te_commit_serializer.sv
// Serializes a bundle of up to NR_PORTS commit lanes onto one trace-encoder lane, lowest lane first.
// Optional TE_SER_STATS_EN adds saturating emit/stall counters.
module te_commit_serializer #(
  parameter int NR_PORTS = 2,
  parameter int XLEN     = 64,
  parameter int ITYPE_W  = 3,
  parameter int IRET_W   = 7,
  localparam int LW      = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_PORTS-1:0]          valid_i,
  input  logic [NR_PORTS*XLEN-1:0]     iaddr_i,
  input  logic [NR_PORTS*ITYPE_W-1:0]  itype_i,
  input  logic [NR_PORTS*IRET_W-1:0]   iretire_i,
  input  logic [NR_PORTS-1:0]          ilastsize_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [XLEN-1:0]              iaddr_o,
  output logic [ITYPE_W-1:0]           itype_o,
  output logic [IRET_W-1:0]            iretire_o,
  output logic                         ilastsize_o,
  output logic [LW-1:0]                lane_o,
  input  logic                         ready_i
`ifdef TE_SER_STATS_EN
  ,
  output logic [31:0]                  emit_cnt_o,
  output logic [31:0]                  stall_cnt_o
`endif
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                            state_q, state_d;
  logic [NR_PORTS-1:0]               pend_q, pend_d;
  logic [NR_PORTS-1:0][XLEN-1:0]     addr_q;
  logic [NR_PORTS-1:0][ITYPE_W-1:0]  itype_q;
  logic [NR_PORTS-1:0][IRET_W-1:0]   iret_q;
  logic [NR_PORTS-1:0]               ils_q;
  logic [NR_PORTS-1:0]               lo;
  logic                              one_left, fire, cap;

  // lo isolates the lowest pending lane as a one-hot mask
  assign lo       = pend_q & (~pend_q + NR_PORTS'(1));
  assign one_left = (pend_q & (pend_q - NR_PORTS'(1))) == '0;
  assign valid_o  = (state_q == EMIT) && !rst_i;
  assign fire     = valid_o && ready_i;
  assign cap      = ready_o && |valid_i;

  always_comb begin
    ready_o = 1'b0;
    if (!rst_i) begin
      if (state_q == IDLE) ready_o = !flush_i;
      else                 ready_o = one_left && ready_i && !flush_i;
    end
  end

  always_comb begin
    iaddr_o     = '0;
    itype_o     = '0;
    iretire_o   = '0;
    ilastsize_o = 1'b0;
    lane_o      = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      if (valid_o && lo[k]) begin
        iaddr_o     = addr_q[k];
        itype_o     = itype_q[k];
        iretire_o   = iret_q[k];
        ilastsize_o = ils_q[k];
        lane_o      = LW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (flush_i) begin
      pend_d  = '0;
      state_d = IDLE;
    end else begin
      if (fire) pend_d = pend_q & ~lo;
      // a capture while draining the last lane reloads without a bubble
      if (cap) begin
        pend_d  = valid_i;
        state_d = EMIT;
      end else if (state_q == EMIT && pend_d == '0) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      itype_q <= '0;
      iret_q  <= '0;
      ils_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (cap) begin
        addr_q  <= iaddr_i;
        itype_q <= itype_i;
        iret_q  <= iretire_i;
        ils_q   <= ilastsize_i;
      end
    end
  end

`ifdef TE_SER_STATS_EN
  logic [31:0] emit_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      emit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && emit_cnt_q != 32'hFFFF_FFFF)                  emit_cnt_q  <= emit_cnt_q + 32'd1;
      if (valid_o && !ready_i && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign emit_cnt_o  = emit_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
